// File: rtl/fifo_rd_burst_reader.sv
// fifo_rd_burst_reader
// Read-side burst consumer for the async FIFO, in the read clock domain.
// It drains burst_len words and re-presents them on a valid/ready stream.
// A 2-entry skid buffer covers the FIFO's 1-cycle read latency.
// Optional build macro: FIFO_RD_TIMEOUT_EN enables the empty-FIFO abort timer.
module fifo_rd_burst_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    input  logic                  half_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  inflight_q;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic                  pop, aborted, fin;
    logic [2:0]            occ;

    assign pop     = m_valid && m_ready;
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = buf0_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    // Buffer slots already claimed: held words plus the word arriving next cycle.
    assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q};
    assign rd_en = (state_q == S_RUN) && !empty && (remain_q != '0) && !aborted &&
                   (occ < (3'd2 + {2'b00, pop}));

    // Burst is finished once nothing is left to issue and everything issued has been handed off.
    assign fin = (state_q == S_RUN) && ((remain_q == '0) || aborted) && !inflight_q &&
                 (cnt_q == 2'd0);

    // Burst control: accept start in IDLE, count issued reads, finish and pulse done.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remain_d = burst_len;
                    state_d  = (burst_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (rd_en) remain_d = remain_q - 1'b1;
                if (fin)   state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Skid buffer: in-order 2-entry queue; head is buf0, capture and pop may coincide.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case ({inflight_q, pop})
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = rd_data;
                end
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = rd_data;
                else               buf1_d = rd_data;
                cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Control and buffer state registers.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            inflight_q <= rd_en;
            cnt_q      <= cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          aborted_q, aborted_d, timeout_q, timeout_d;

    assign aborted = aborted_q;
    assign timeout = timeout_q;

    // Empty-FIFO timer: counts starved RUN cycles; a refilling FIFO (half_empty=0) holds it clear.
    always_comb begin
        tmr_d     = tmr_q;
        aborted_d = aborted_q;
        timeout_d = timeout_q;
        if ((state_q == S_IDLE) && start) begin
            tmr_d     = '0;
            aborted_d = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == S_RUN) begin
            if (!empty || !half_empty || (remain_q == '0) || aborted_q) begin
                tmr_d = '0;
            end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmr_d     = '0;
                aborted_d = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
            if (fin) timeout_d = aborted_q;
        end
    end

    // Timer and abort flag registers.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            tmr_q     <= '0;
            aborted_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            aborted_q <= aborted_d;
            timeout_q <= timeout_d;
        end
    end
`else
    logic        unused_half_empty;
    logic [31:0] unused_timeout_cycles;

    assign unused_half_empty     = half_empty;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign aborted               = 1'b0;
    assign timeout               = 1'b0;
`endif

endmodule
